cpldintf_gen: RTL and testbench
===============================

# cpldintf_gen

Parametrised CPLD-to-FPGA microprocessor bridge. It converts a PW-bit multiplexed, pcs-framed pin bus into single-cycle-addressed DW = PW×NW-bit internal register accesses (up_*), one pin-bus word per pcs frame. It buffers partial words in both directions and resolves each access with up_rdy or a programmable timeout. It sits between the board CPLD pins and the FPGA register decoder, and replaces the fixed 16/32-bit bridge with explicit FSM control, registered write data and sticky timeout reporting.

## Interface
- PW, 16: pin-bus data width.
- NW, 2: pin words per internal word (power of 2, ≥2); WB = log2(NW).
- AW, 24: internal address width; HA = AW − (PW − WB) haddr bits are used, and HA ≤ PW−1 is required.
- TOUT, 4095: ACCESS-state cycles before timeout (≥2).
- TOVAL, 16'hCAFE: PW-bit data returned on timeout.
- sclk  in  1  system clock
- rst_  in  1  async active-low reset
- pcs  in  1  pin chip select, high frames one transaction
- pdi  in  PW  pin data in (haddr, laddr, data phases)
- pdo  out  PW  pin read data
- pdoe  out  1  pdo output enable
- prdy  out  1  transaction complete
- pint, pintoe  out  1  interrupt / interrupt OE to pins
- up_addr  out  AW  {haddr[HA−1:0], laddr[PW−1:WB]}
- up_rd, up_wr, up_rnw  out  1  access qualifiers
- up_cs_  out  1  internal chip select, active low, registered
- up_wrd  out  DW  registered write data
- up_rdd  in  DW  read data
- up_rdy  in  1  access done pulse
- up_int, up_intoe  in  1  interrupt sources
- err_clr  in  1  clears tout_err
- tout_err  out  1  sticky timeout flag

## Operation
- Phases: haddr = first pdi word (haddr[PW−1] = 1 means write); laddr = second; idx = laddr[WB−1:0] is the word index; data = third word (write only).
- FSM states: IDLE, LADDR, DATA, ACCESS, DONE.
- IDLE, pcs=1: capture haddr, go to LADDR.
- LADDR: capture laddr.
  - Read, idx=0: up_cs_←0, go to ACCESS.
  - Read, idx≠0: go to DONE.
  - Write: go to DATA.
- DATA: wrbuf[idx]←pdi.
  - idx=NW−1: up_wrd←{pdi, wrbuf[NW−2:0]}, up_cs_←0, go to ACCESS.
  - Otherwise: go to DONE.
- ACCESS: tcnt increments each cycle.
  - up_rdy: up_cs_←1; on read, rdbuf←up_rdd; go to DONE.
  - tcnt==TOUT−1 with no up_rdy: up_cs_←1, tout_err←1, toflag←1, go to DONE.
  - up_rdy and timeout in the same cycle: up_rdy wins and no error is set.
- DONE: prdy=1; hold until pcs=0.
- pcs=0 in any state: next state IDLE; up_cs_←1, prdy←0, tcnt←0, toflag←0. Buffers are kept, so a pcs drop mid-ACCESS aborts with no error.
- Combinational outputs:
  - up_rd = !up_cs_ & !haddr[PW−1]
  - up_wr = !up_cs_ & haddr[PW−1]
  - up_rnw = up_rd
  - pdo = toflag ? TOVAL : rdbuf[idx]
  - pdoe = pcs & read & state ∈ {ACCESS, DONE}
- pint is up_int registered; pintoe = up_intoe.
- tout_err: set has priority over err_clr when both occur in the same cycle.
- Reset values: FSM=IDLE, up_cs_=1, prdy=0, pint=0, tout_err=0, pdoe=0, haddr=laddr=0, wrbuf/rdbuf all words=TOVAL, up_wrd=0.

## Timing
- Edge E1 is the first sclk edge with pcs=1.
  - E1: haddr captured.
  - E2: laddr captured.
  - E3: write data captured.
- Read idx=0: up_cs_ low after E2. With up_rdy sampled at edge En, rdbuf and prdy update at En; minimum prdy at E3.
- Read idx≠0: prdy after E2, no up access.
- Write idx<NW−1: prdy after E3.
- Write idx=NW−1: up_cs_ low after E3; up_wrd is stable while up_cs_ is low.
- up_cs_ returns high on the edge sampling up_rdy; one access per frame.
- Timeout: prdy follows TOUT cycles after ACCESS entry.
- Asynchronous reset mid-transaction forces the reset values immediately.

## Structure
- Shared package holds:
  - the FSM state enum
  - the WB/HA derivation functions
  - the default TOVAL constant
- No sub-modules; the timeout counter stays inline (width clog2(TOUT+1)).

## Test plan
- Write 0x1234 to idx0, then 0xABCD to idx1, with haddr=0x8005, laddr=0x0010/0x0011 → wrbuf0 held; one up_wr pulse at up_addr=0x028008, up_wrd=0xABCD1234; prdy each frame.
- Read with haddr=0x0005, laddr=0x0010, up_rdd=0xDEADBEEF, up_rdy 2 cycles later → pdo=0xBEEF, prdy; next frame laddr=0x0011 → pdo=0xDEAD with no up_cs_.
- Read, up_rdy never arrives (TOUT=16) → up_cs_ released after 16 cycles, pdo=0xCAFE, prdy=1, tout_err=1; err_clr → 0.
- up_rdy on the exact timeout cycle → normal data returned, tout_err stays 0.
- pcs dropped mid-ACCESS → up_cs_=1 and FSM=IDLE next edge, no error; a following read completes normally.
- Assert rst_ during ACCESS → up_cs_=1, prdy=0, buffers=0xCAFE immediately.

Source files
------------

// File: rtl/cpldintf_gen_pkg.sv
// -----------------------------------------------------------------------------
// cpldintf_gen_pkg
// Shared definitions for the CPLD-to-FPGA microprocessor bridge:
//   - FSM state enumeration
//   - derivation helpers for the word-index width (WB) and the number of
//     haddr bits that reach the internal address (HA)
//   - default data word returned on an access timeout
// -----------------------------------------------------------------------------
package cpldintf_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LADDR,
        ST_DATA,
        ST_ACCESS,
        ST_DONE
    } state_t;

    localparam logic [15:0] DEF_TOVAL = 16'hCAFE;

    // Number of laddr bits that select a pin word inside an internal word.
    function automatic int wb_of(input int nw);
        return $clog2(nw);
    endfunction

    // Number of haddr bits used on top of laddr[PW-1:WB] to fill AW bits.
    function automatic int ha_of(input int aw, input int pw, input int nw);
        return aw - (pw - $clog2(nw));
    endfunction

endpackage

// File: rtl/cpldintf_gen.sv
// -----------------------------------------------------------------------------
// cpldintf_gen
// Bridge between a PW-bit multiplexed, pcs-framed CPLD pin bus and a
// DW = PW*NW bit internal register bus. Each pcs frame carries one pin word:
// haddr (bit PW-1 = write), laddr (low bits = word index), then data for
// writes. Partial words are buffered in both directions; an internal access
// is only issued for a read of word 0 or a write of word NW-1. Each access
// ends on up_rdy or after TOUT cycles, the latter returning TOVAL and setting
// a sticky error flag.
//
// Ports
//   sclk, rst_          clock, asynchronous active-low reset
//   pcs, pdi            pin frame select and multiplexed pin data in
//   pdo, pdoe, prdy     pin read data, its output enable, frame complete
//   pint, pintoe        interrupt (registered) and its output enable to pins
//   up_addr             internal word address {haddr[HA-1:0], laddr[PW-1:WB]}
//   up_rd, up_wr,
//   up_rnw, up_cs_      access qualifiers, up_cs_ active low and registered
//   up_wrd              registered internal write data
//   up_rdd, up_rdy      internal read data and access-done pulse
//   up_int, up_intoe    interrupt sources from the register side
//   err_clr, tout_err   clear input and sticky timeout flag
// -----------------------------------------------------------------------------
module cpldintf_gen
    import cpldintf_gen_pkg::*;
#(
    parameter int              PW    = 16,
    parameter int              NW    = 2,
    parameter int              AW    = 24,
    parameter int              TOUT  = 4095,
    parameter logic [PW-1:0]   TOVAL = PW'(DEF_TOVAL)
) (
    input  logic               sclk,
    input  logic               rst_,
    input  logic               pcs,
    input  logic [PW-1:0]      pdi,
    output logic [PW-1:0]      pdo,
    output logic               pdoe,
    output logic               prdy,
    output logic               pint,
    output logic               pintoe,
    output logic [AW-1:0]      up_addr,
    output logic               up_rd,
    output logic               up_wr,
    output logic               up_rnw,
    output logic               up_cs_,
    output logic [PW*NW-1:0]   up_wrd,
    input  logic [PW*NW-1:0]   up_rdd,
    input  logic               up_rdy,
    input  logic               up_int,
    input  logic               up_intoe,
    input  logic               err_clr,
    output logic               tout_err
);

    localparam int WB  = wb_of(NW);
    localparam int HA  = ha_of(AW, PW, NW);
    localparam int DW  = PW * NW;
    localparam int TCW = $clog2(TOUT + 1);

    localparam logic [WB-1:0]  IDX_LAST = WB'(NW - 1);
    localparam logic [TCW-1:0] TC_LAST  = TCW'(TOUT - 1);

    state_t              state_reg, state_next;
    logic [PW-1:0]       haddr_reg;
    logic [PW-1:0]       laddr_reg;
    logic [PW-1:0]       wrbuf_reg [NW];
    logic [PW-1:0]       rdbuf_reg [NW];
    logic [DW-1:0]       up_wrd_reg;
    logic                up_cs_reg;
    logic                prdy_reg;
    logic [TCW-1:0]      tcnt_reg;
    logic                toflag_reg;
    logic                tout_err_reg;
    logic                pint_reg;

    logic                is_wr;
    logic [WB-1:0]       idx;
    logic                rd_start;
    logic                wr_start;
    logic                access_done;
    logic                timeout_hit;
    logic [DW-1:0]       wr_assemble;

    assign is_wr = haddr_reg[PW-1];
    assign idx   = laddr_reg[WB-1:0];

    // A read of word 0 fetches the whole internal word; reads of the other
    // words are served from rdbuf without touching the register bus.
    assign rd_start    = pcs && (state_reg == ST_LADDR) && !is_wr && (pdi[WB-1:0] == '0);
    // Only the last pin word of a write launches the internal write.
    assign wr_start    = pcs && (state_reg == ST_DATA) && (idx == IDX_LAST);
    assign access_done = pcs && (state_reg == ST_ACCESS) && up_rdy;
    // up_rdy arriving on the final count wins over the timeout.
    assign timeout_hit = pcs && (state_reg == ST_ACCESS) && !up_rdy && (tcnt_reg == TC_LAST);

    // Write word assembly: last word straight from the pins, lower words
    // from the buffer filled by earlier frames.
    generate
        for (genvar gi = 0; gi < NW; gi++) begin : g_wr_asm
            if (gi == NW - 1) begin : g_last
                assign wr_assemble[gi*PW +: PW] = pdi;
            end else begin : g_buf
                assign wr_assemble[gi*PW +: PW] = wrbuf_reg[gi];
            end
        end
    endgenerate

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (!pcs) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:   state_next = ST_LADDR;
                ST_LADDR: begin
                    if (is_wr)
                        state_next = ST_DATA;
                    else if (pdi[WB-1:0] == '0)
                        state_next = ST_ACCESS;
                    else
                        state_next = ST_DONE;
                end
                ST_DATA:   state_next = (idx == IDX_LAST) ? ST_ACCESS : ST_DONE;
                ST_ACCESS: begin
                    if (up_rdy || timeout_hit)
                        state_next = ST_DONE;
                end
                ST_DONE:   state_next = ST_DONE;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    // Control and address registers
    always_ff @(posedge sclk or negedge rst_) begin
        if (!rst_) begin
            state_reg    <= ST_IDLE;
            haddr_reg    <= '0;
            laddr_reg    <= '0;
            up_wrd_reg   <= '0;
            up_cs_reg    <= 1'b1;
            prdy_reg     <= 1'b0;
            tcnt_reg     <= '0;
            toflag_reg   <= 1'b0;
            tout_err_reg <= 1'b0;
            pint_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            prdy_reg  <= (state_next == ST_DONE);
            pint_reg  <= up_int;

            if (pcs && state_reg == ST_IDLE)
                haddr_reg <= pdi;
            if (pcs && state_reg == ST_LADDR)
                laddr_reg <= pdi;
            if (wr_start)
                up_wrd_reg <= wr_assemble;

            if (rd_start || wr_start)
                up_cs_reg <= 1'b0;
            else if (!pcs || access_done || timeout_hit)
                up_cs_reg <= 1'b1;

            if (pcs && state_reg == ST_ACCESS)
                tcnt_reg <= tcnt_reg + 1'b1;
            else
                tcnt_reg <= '0;

            if (!pcs)
                toflag_reg <= 1'b0;
            else if (timeout_hit)
                toflag_reg <= 1'b1;

            if (timeout_hit)
                tout_err_reg <= 1'b1;
            else if (err_clr)
                tout_err_reg <= 1'b0;
        end
    end

    // Per-word data buffers; they survive pcs drops and only reset to TOVAL.
    generate
        for (genvar gi = 0; gi < NW; gi++) begin : g_buf
            always_ff @(posedge sclk or negedge rst_) begin
                if (!rst_) begin
                    wrbuf_reg[gi] <= TOVAL;
                    rdbuf_reg[gi] <= TOVAL;
                end else begin
                    if (pcs && state_reg == ST_DATA && idx == WB'(gi))
                        wrbuf_reg[gi] <= pdi;
                    if (access_done && !is_wr)
                        rdbuf_reg[gi] <= up_rdd[gi*PW +: PW];
                end
            end
        end
    endgenerate

    assign up_addr  = {haddr_reg[HA-1:0], laddr_reg[PW-1:WB]};
    assign up_cs_   = up_cs_reg;
    assign up_rd    = !up_cs_reg && !is_wr;
    assign up_wr    = !up_cs_reg && is_wr;
    assign up_rnw   = up_rd;
    assign up_wrd   = up_wrd_reg;
    assign pdo      = toflag_reg ? TOVAL : rdbuf_reg[idx];
    assign pdoe     = pcs && !is_wr && (state_reg == ST_ACCESS || state_reg == ST_DONE);
    assign prdy     = prdy_reg;
    assign pint     = pint_reg;
    assign pintoe   = up_intoe;
    assign tout_err = tout_err_reg;

endmodule

// File: tb/tb_cpldintf_gen.sv
// -----------------------------------------------------------------------------
// tb_cpldintf_gen
// Directed bench for cpldintf_gen (TOUT reduced to 16). Expected internal
// accesses and frame completions are queued when a frame is issued; a monitor
// pops and compares them when up_cs_ falls or prdy rises. An up_rdy responder
// answers each access after a programmable number of cycles.
// -----------------------------------------------------------------------------
module tb_cpldintf_gen;

    localparam int PW   = 16;
    localparam int NW   = 2;
    localparam int AW   = 24;
    localparam int DW   = PW * NW;
    localparam int TOUT = 16;

    logic           sclk = 1'b0;
    logic           rst_;
    logic           pcs;
    logic [PW-1:0]  pdi;
    logic [PW-1:0]  pdo;
    logic           pdoe;
    logic           prdy;
    logic           pint;
    logic           pintoe;
    logic [AW-1:0]  up_addr;
    logic           up_rd;
    logic           up_wr;
    logic           up_rnw;
    logic           up_cs_;
    logic [DW-1:0]  up_wrd;
    logic [DW-1:0]  up_rdd;
    logic           up_rdy;
    logic           up_int;
    logic           up_intoe;
    logic           err_clr;
    logic           tout_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic           is_read;
        logic [PW-1:0]  pdo;
        logic           terr;
    } cpl_t;

    typedef struct {
        logic [AW-1:0]  addr;
        logic           is_wr;
        logic [DW-1:0]  wrd;
    } acc_t;

    cpl_t cpl_q[$];
    acc_t acc_q[$];
    cpl_t mon_c;
    acc_t mon_a;
    logic prev_prdy = 1'b0;
    logic prev_cs   = 1'b1;
    int   rdy_k     = -1;   // up_rdy sampled on the k-th edge after up_cs_ falls; -1 = never
    int   rdy_wc    = 0;

    cpldintf_gen #(
        .PW    (PW),
        .NW    (NW),
        .AW    (AW),
        .TOUT  (TOUT),
        .TOVAL (16'hCAFE)
    ) dut (
        .sclk     (sclk),
        .rst_     (rst_),
        .pcs      (pcs),
        .pdi      (pdi),
        .pdo      (pdo),
        .pdoe     (pdoe),
        .prdy     (prdy),
        .pint     (pint),
        .pintoe   (pintoe),
        .up_addr  (up_addr),
        .up_rd    (up_rd),
        .up_wr    (up_wr),
        .up_rnw   (up_rnw),
        .up_cs_   (up_cs_),
        .up_wrd   (up_wrd),
        .up_rdd   (up_rdd),
        .up_rdy   (up_rdy),
        .up_int   (up_int),
        .up_intoe (up_intoe),
        .err_clr  (err_clr),
        .tout_err (tout_err)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // up_rdy responder
    initial begin
        up_rdy = 1'b0;
        forever begin
            @(posedge sclk);
            #1;
            if (up_cs_ === 1'b0) begin
                rdy_wc++;
                up_rdy = (rdy_k > 0) && (rdy_wc == rdy_k);
            end else begin
                rdy_wc = 0;
                up_rdy = 1'b0;
            end
        end
    end

    // Monitor: compares queued expectations on up_cs_ fall and prdy rise
    initial begin
        forever begin
            @(negedge sclk);
            if (rst_ === 1'b1) begin
                if (up_cs_ === 1'b0 && prev_cs === 1'b1) begin
                    if (acc_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_access: up_cs_ fell at addr %h, no access expected", up_addr);
                    end else begin
                        mon_a = acc_q.pop_front();
                        chk("up_addr", 32'(up_addr), 32'(mon_a.addr));
                        chk("up_wr",   32'(up_wr),   32'(mon_a.is_wr));
                        chk("up_rd",   32'(up_rd),   32'(!mon_a.is_wr));
                        chk("up_rnw",  32'(up_rnw),  32'(!mon_a.is_wr));
                        if (mon_a.is_wr)
                            chk("up_wrd", up_wrd, mon_a.wrd);
                        $display("access addr=%h wr=%0d wrd=%h", up_addr, up_wr, up_wrd);
                    end
                end
                if (prdy === 1'b1 && prev_prdy === 1'b0) begin
                    if (cpl_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_prdy: prdy rose with no frame expected, pdo %h", pdo);
                    end else begin
                        mon_c = cpl_q.pop_front();
                        chk("pdoe", 32'(pdoe), 32'(mon_c.is_read));
                        if (mon_c.is_read)
                            chk("pdo", 32'(pdo), 32'(mon_c.pdo));
                        chk("tout_err", 32'(tout_err), 32'(mon_c.terr));
                        $display("frame done read=%0d pdo=%h tout_err=%0d", mon_c.is_read, pdo, tout_err);
                    end
                end
            end
            prev_cs   = up_cs_;
            prev_prdy = prdy;
        end
    end

    // Drive the haddr/laddr/(data) phases; returns one #1 after the last phase edge.
    task automatic start_frame(input logic [PW-1:0] ha, input logic [PW-1:0] la,
                               input logic [PW-1:0] d);
        @(posedge sclk); #1;
        pcs = 1'b1;
        pdi = ha;
        @(posedge sclk); #1;
        pdi = la;
        @(posedge sclk); #1;
        if (ha[PW-1]) begin
            pdi = d;
            @(posedge sclk); #1;
        end
    endtask

    // Wait (bounded) for prdy, hold pcs one more cycle, then close the frame.
    task automatic finish_frame();
        int n = 0;
        while (prdy !== 1'b1 && n < 200) begin
            @(posedge sclk); #1;
            n++;
        end
        chk("prdy_seen", 32'(prdy), 32'd1);
        @(posedge sclk); #1;
        pcs = 1'b0;
        pdi = '0;
        @(posedge sclk); #1;
        @(posedge sclk); #1;
    endtask

    task automatic do_frame(input logic [PW-1:0] ha, input logic [PW-1:0] la,
                            input logic [PW-1:0] d);
        start_frame(ha, la, d);
        finish_frame();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_     = 1'b0;
        pcs      = 1'b0;
        pdi      = '0;
        up_rdd   = '0;
        up_int   = 1'b0;
        up_intoe = 1'b0;
        err_clr  = 1'b0;

        // Reset state
        repeat (2) @(posedge sclk);
        #1;
        chk("rst_up_cs_",   32'(up_cs_),   32'd1);
        chk("rst_prdy",     32'(prdy),     32'd0);
        chk("rst_pint",     32'(pint),     32'd0);
        chk("rst_tout_err", 32'(tout_err), 32'd0);
        chk("rst_pdoe",     32'(pdoe),     32'd0);
        chk("rst_pdo",      32'(pdo),      32'h0000CAFE);
        chk("rst_up_wrd",   up_wrd,        32'h0);
        chk("rst_up_addr",  32'(up_addr),  32'h0);

        @(posedge sclk); #1;
        rst_ = 1'b1;

        // Interrupt path
        up_int   = 1'b1;
        up_intoe = 1'b1;
        @(posedge sclk); #1;
        chk("pint_hi",   32'(pint),   32'd1);
        chk("pintoe_hi", 32'(pintoe), 32'd1);
        up_int   = 1'b0;
        up_intoe = 1'b0;
        @(posedge sclk); #1;
        chk("pint_lo",   32'(pint),   32'd0);
        chk("pintoe_lo", 32'(pintoe), 32'd0);

        // Write word 0 (buffered only), then word 1 (launches the access)
        rdy_k = 1;
        cpl_q.push_back('{1'b0, 16'h0000, 1'b0});
        do_frame(16'h8005, 16'h0010, 16'h1234);
        acc_q.push_back('{24'h028008, 1'b1, 32'hABCD1234});
        cpl_q.push_back('{1'b0, 16'h0000, 1'b0});
        do_frame(16'h8005, 16'h0011, 16'hABCD);

        // Read word 0 with up_rdy two cycles after up_cs_, then word 1 from buffer
        rdy_k  = 2;
        up_rdd = 32'hDEADBEEF;
        acc_q.push_back('{24'h028008, 1'b0, 32'h0});
        cpl_q.push_back('{1'b1, 16'hBEEF, 1'b0});
        do_frame(16'h0005, 16'h0010, 16'h0000);
        cpl_q.push_back('{1'b1, 16'hDEAD, 1'b0});
        do_frame(16'h0005, 16'h0011, 16'h0000);

        // Timeout: up_rdy never arrives
        rdy_k = -1;
        acc_q.push_back('{24'h028008, 1'b0, 32'h0});
        cpl_q.push_back('{1'b1, 16'hCAFE, 1'b1});
        do_frame(16'h0005, 16'h0010, 16'h0000);
        chk("tout_err_sticky", 32'(tout_err), 32'd1);
        err_clr = 1'b1;
        @(posedge sclk); #1;
        err_clr = 1'b0;
        chk("tout_err_cleared", 32'(tout_err), 32'd0);

        // up_rdy on the exact timeout cycle wins
        rdy_k  = TOUT;
        up_rdd = 32'h55AA1234;
        acc_q.push_back('{24'h028008, 1'b0, 32'h0});
        cpl_q.push_back('{1'b1, 16'h1234, 1'b0});
        do_frame(16'h0005, 16'h0010, 16'h0000);
        chk("edge_tout_err", 32'(tout_err), 32'd0);

        // pcs dropped mid-access
        rdy_k = -1;
        acc_q.push_back('{24'h028008, 1'b0, 32'h0});
        start_frame(16'h0005, 16'h0010, 16'h0000);
        repeat (5) begin
            @(posedge sclk); #1;
        end
        pcs = 1'b0;
        @(posedge sclk); #1;
        chk("abort_up_cs_",   32'(up_cs_),   32'd1);
        chk("abort_tout_err", 32'(tout_err), 32'd0);
        chk("abort_prdy",     32'(prdy),     32'd0);
        chk("abort_pdoe",     32'(pdoe),     32'd0);
        @(posedge sclk); #1;
        rdy_k  = 1;
        up_rdd = 32'h13572468;
        acc_q.push_back('{24'h028008, 1'b0, 32'h0});
        cpl_q.push_back('{1'b1, 16'h2468, 1'b0});
        do_frame(16'h0005, 16'h0010, 16'h0000);

        // Asynchronous reset during an access
        rdy_k = -1;
        acc_q.push_back('{24'h028008, 1'b0, 32'h0});
        start_frame(16'h0005, 16'h0010, 16'h0000);
        repeat (3) begin
            @(posedge sclk); #1;
        end
        @(negedge sclk); #2;
        rst_ = 1'b0;
        #1;
        chk("arst_up_cs_", 32'(up_cs_), 32'd1);
        chk("arst_prdy",   32'(prdy),   32'd0);
        chk("arst_pdo",    32'(pdo),    32'h0000CAFE);
        chk("arst_pdoe",   32'(pdoe),   32'd0);
        chk("arst_up_wrd", up_wrd,      32'h0);
        pcs = 1'b0;
        @(posedge sclk); #1;
        rst_ = 1'b1;
        @(posedge sclk); #1;
        // Word 1 of the read buffer must be back at the timeout value
        cpl_q.push_back('{1'b1, 16'hCAFE, 1'b0});
        do_frame(16'h0005, 16'h0011, 16'h0000);

        repeat (2) @(posedge sclk);
        #1;
        chk("acc_q_drained", 32'(acc_q.size()), 32'd0);
        chk("cpl_q_drained", 32'(cpl_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
